// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU operation controller: datapath width,
// multiplexer select codes and the controller state encoding.
package alu4_pkg;

    localparam int WIDTH = 4;

    // Result multiplexer select codes (the controller passes these through untouched)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu4_ctrl_cnt4_dn.sv
// Loadable 4-bit down-counter holding the remaining repeat count of an
// operation. zero_o tells the controller the current EXEC cycle is the last.
module cnt4_dn
    import alu4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: load wins over decrement; decrement never wraps below zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/alu4_ctrl.sv
// Operation controller for the 4-bit ALU. Accepts load/operation commands,
// drives the result multiplexer selects, owns the accumulator (operand A)
// and the zero/carry flags, and repeats an operation cmd_rep+1 times.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE with reset low;
// cmd_valid while busy is ignored and cmd_* need only be stable at that edge.
module alu4_ctrl
    import alu4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_load,
    input  logic [WIDTH-1:0] cmd_rep,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_co,
    output logic [WIDTH-1:0] acc,
    output logic             flag_z,
    output logic             flag_c,
    output logic             done,
    output state_t           dbg_state
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       sel_q, sel_d;
    logic             fz_q, fz_d;
    logic             fc_q, fc_d;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [WIDTH-1:0] cnt_val;
    logic             accept;
    logic [2:0]       sel_out;

    assign cmd_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;

    cnt4_dn u_rep_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cmd_rep),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // Next-state and datapath-register update for IDLE / EXEC / DONE
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        sel_d    = sel_q;
        fz_d     = fz_q;
        fc_d     = fc_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_load) begin
                        acc_d   = cmd_b;
                        fz_d    = (cmd_b == '0);
                        fc_d    = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        sel_d    = cmd_op;
                        b_d      = cmd_b;
                        cnt_load = 1'b1;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                acc_d = alu_y;
                fc_d  = alu_co;
                fz_d  = (alu_y == '0);
                if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any command in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            sel_q   <= 3'b000;
            fz_q    <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            fz_q    <= fz_d;
            fc_q    <= fc_d;
        end
    end

    // Selects carry the latched opcode only while an operation executes
    assign sel_out   = (state_q == ST_EXEC) ? sel_q : 3'b000;
    assign s2        = sel_out[2];
    assign s1        = sel_out[1];
    assign s0        = sel_out[0];
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign acc       = acc_q;
    assign flag_z    = fz_q;
    assign flag_c    = fc_q;
    assign done      = (state_q == ST_DONE) && !reset;
    assign dbg_state = state_q;

    // The counter value itself is only observed through its zero flag
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_alu4_ctrl.sv
// Bench for alu4_ctrl with a behavioural 8-to-1 result multiplexer stage.
module tb_alu4_ctrl;
    import alu4_pkg::*;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_b;
    logic       cmd_load;
    logic [3:0] cmd_rep;
    logic       s2, s1, s0;
    logic [3:0] alu_a, alu_b, alu_y;
    logic       alu_co;
    logic [3:0] acc;
    logic       flag_z, flag_c, done;
    state_t     dbg_state;

    int errors = 0;
    int checks = 0;

    alu4_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_b     (cmd_b),
        .cmd_load  (cmd_load),
        .cmd_rep   (cmd_rep),
        .s2        (s2),
        .s1        (s1),
        .s0        (s0),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_co    (alu_co),
        .acc       (acc),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result multiplexer stage and function units outside the controller
    logic [4:0] wide;
    always_comb begin
        wide = 5'd0;
        case ({s2, s1, s0})
            OP_ADD: wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: wide = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: wide = {1'b0, alu_a & alu_b};
            OP_OR:  wide = {1'b0, alu_a | alu_b};
            OP_XOR: wide = {1'b0, alu_a ^ alu_b};
            OP_NOT: wide = {1'b0, ~alu_a};
            OP_SHL: wide = {alu_a[3], alu_a[2:0], 1'b0};
            OP_SHR: wide = {alu_a[0], 1'b0, alu_a[3:1]};
            default: wide = 5'd0;
        endcase
        alu_y  = wide[3:0];
        alu_co = wide[4];
    end

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for cmd_ready
    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL ready_timeout: cmd_ready=%b want 1 after %0d cycles", cmd_ready, n);
        end
    endtask

    // Driver: load; on return the bench sits in cycle 1 (DONE)
    task automatic send_load(input logic [3:0] b);
        wait_ready();
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = b; cmd_op = 3'd0; cmd_rep = 4'd0;
        tick();
        cmd_valid = 1'b0; cmd_load = 1'b0;
    endtask

    // Driver: operation; on return the bench sits in cycle 1 (first EXEC)
    task automatic send_op(input logic [2:0] op, input logic [3:0] b, input logic [3:0] rep);
        wait_ready();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = op; cmd_b = b; cmd_rep = rep;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0;
        cmd_op = 3'd0; cmd_b = 4'd0; cmd_rep = 4'd0;
        tick(); tick();
        checks++;
        if ({acc, flag_z, flag_c, done, cmd_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_vals: acc=%h z=%b c=%b done=%b rdy=%b want all 0", acc, flag_z, flag_c, done, cmd_ready);
        end
        checks++;
        if ({s2, s1, s0, alu_b} !== 7'd0) begin
            errors++;
            $display("FAIL reset_sel: sel=%b b=%h want 000/0", {s2, s1, s0}, alu_b);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_release: rdy=%b state=%0d want 1/IDLE", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_load_add();
        send_load(4'h5);
        checks++;
        if (done !== 1'b1 || acc !== 4'h5 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_c1: done=%b acc=%h rdy=%b want 1/5/0", done, acc, cmd_ready);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL load_c2: rdy=%b done=%b want 1/0", cmd_ready, done);
        end
        send_op(OP_ADD, 4'h3, 4'd0);
        checks++;
        if (done !== 1'b0 || alu_b !== 4'h3 || dbg_state !== ST_EXEC) begin
            errors++;
            $display("FAIL add_c1: done=%b b=%h state=%0d want 0/3/EXEC", done, alu_b, dbg_state);
        end
        tick();
        checks++;
        if (done !== 1'b1 || acc !== 4'h8 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL add_c2: done=%b acc=%h z=%b c=%b want 1/8/0/0", done, acc, flag_z, flag_c);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL add_c3: rdy=%b done=%b want 1/0", cmd_ready, done);
        end
    endtask

    task automatic test_wrap();
        send_load(4'hF);
        tick();
        send_op(OP_ADD, 4'h1, 4'd0);
        tick();
        checks++;
        if (acc !== 4'h0 || flag_z !== 1'b1 || flag_c !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL wrap: acc=%h z=%b c=%b done=%b want 0/1/1/1", acc, flag_z, flag_c, done);
        end
        tick();
        // a load clears the carry left by the wrapping add
        send_load(4'h0);
        checks++;
        if (flag_c !== 1'b0 || flag_z !== 1'b1) begin
            errors++;
            $display("FAIL load_flags: c=%b z=%b want 0/1", flag_c, flag_z);
        end
        tick();
    endtask

    task automatic test_repeat();
        logic [3:0] exp_acc [0:5];
        exp_acc[0] = 4'h0; exp_acc[1] = 4'h3; exp_acc[2] = 4'h6;
        exp_acc[3] = 4'h9; exp_acc[4] = 4'hC; exp_acc[5] = 4'hF;
        send_load(4'h0);
        tick();
        send_op(OP_ADD, 4'h3, 4'd4);
        // a load command kept valid while busy must be ignored
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_b = 4'h9;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (acc !== exp_acc[c-1] || cmd_ready !== 1'b0 || done !== (c == 6)) begin
                errors++;
                $display("FAIL rep_cycle%0d: acc=%h rdy=%b done=%b want %h/0/%b", c, acc, cmd_ready, done, exp_acc[c-1], (c == 6));
            end
            if (c == 6) cmd_valid = 1'b0;
            else tick();
        end
        cmd_load = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || acc !== 4'hF || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL rep_end: rdy=%b acc=%h c=%b want 1/F/0", cmd_ready, acc, flag_c);
        end
    endtask

    task automatic test_selects();
        send_load(4'h5);
        tick();
        send_op(OP_OR, 4'hA, 4'd1);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if ({s2, s1, s0} !== OP_OR || alu_b !== 4'hA || alu_a !== acc) begin
                errors++;
                $display("FAIL sel_exec%0d: sel=%b b=%h a=%h want 011/A/acc", c, {s2, s1, s0}, alu_b, alu_a);
            end
            tick();
        end
        checks++;
        if (acc !== 4'hF || done !== 1'b1 || {s2, s1, s0} !== 3'b000) begin
            errors++;
            $display("FAIL or_res: acc=%h done=%b sel=%b want F/1/000", acc, done, {s2, s1, s0});
        end
        tick();
        send_load(4'h3);
        tick();
        send_op(OP_SHR, 4'h0, 4'd1);
        tick();
        checks++;
        if (acc !== 4'h1 || flag_c !== 1'b1 || {s2, s1, s0} !== OP_SHR) begin
            errors++;
            $display("FAIL shr1: acc=%h c=%b sel=%b want 1/1/111", acc, flag_c, {s2, s1, s0});
        end
        tick();
        checks++;
        if (acc !== 4'h0 || flag_c !== 1'b1 || flag_z !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL shr2: acc=%h c=%b z=%b done=%b want 0/1/1/1", acc, flag_c, flag_z, done);
        end
        tick();
    endtask

    task automatic test_abort();
        send_load(4'h0);
        tick();
        send_op(OP_ADD, 4'h1, 4'd15);
        tick(); tick();
        checks++;
        if (acc !== 4'h2 || dbg_state !== ST_EXEC) begin
            errors++;
            $display("FAIL abort_pre: acc=%h state=%0d want 2/EXEC", acc, dbg_state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_rdy: rdy=%b done=%b want 0/0", cmd_ready, done);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (acc !== 4'h0 || dbg_state !== ST_IDLE || {s2, s1, s0} !== 3'b000 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_post: acc=%h state=%0d sel=%b done=%b rdy=%b want 0/IDLE/000/0/1", acc, dbg_state, {s2, s1, s0}, done, cmd_ready);
        end
        tick(); tick();
        checks++;
        if (done !== 1'b0 || acc !== 4'h0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL abort_quiet: done=%b acc=%h state=%0d want 0/0/IDLE", done, acc, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        send_load(4'h7);
        tick();
        wait_ready();
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = OP_SUB; cmd_b = 4'h2; cmd_rep = 4'd0;
        tick();
        // the queued XOR is presented immediately and held
        cmd_op = OP_XOR; cmd_b = 4'hF;
        checks++;
        if (cmd_ready !== 1'b0 || alu_b !== 4'h2 || {s2, s1, s0} !== OP_SUB) begin
            errors++;
            $display("FAIL b2b_exec: rdy=%b b=%h sel=%b want 0/2/001", cmd_ready, alu_b, {s2, s1, s0});
        end
        tick();
        checks++;
        if (acc !== 4'h5 || done !== 1'b1 || cmd_ready !== 1'b0 || flag_c !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sub: acc=%h done=%b rdy=%b c=%b want 5/1/0/0", acc, done, cmd_ready, flag_c);
        end
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || acc !== 4'h5) begin
            errors++;
            $display("FAIL b2b_ready: rdy=%b acc=%h want 1/5", cmd_ready, acc);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (dbg_state !== ST_EXEC || alu_b !== 4'hF || {s2, s1, s0} !== OP_XOR) begin
            errors++;
            $display("FAIL b2b_accept: state=%0d b=%h sel=%b want EXEC/F/100", dbg_state, alu_b, {s2, s1, s0});
        end
        tick();
        checks++;
        if (acc !== 4'hA || done !== 1'b1 || flag_z !== 1'b0) begin
            errors++;
            $display("FAIL b2b_xor: acc=%h done=%b z=%b want A/1/0", acc, done, flag_z);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_add();
        test_wrap();
        test_repeat();
        test_selects();
        test_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu4_ctrl.md
# alu4_ctrl

Operation controller for the 4-bit ALU. It accepts commands over a valid/ready handshake and drives the 3-bit select lines (s2, s1, s0) of the 8-to-1 result multiplexer stage. It holds the accumulator that feeds operand A, writes each multiplexer result back into that accumulator, and keeps zero and carry flags. An optional repeat count executes one operation up to 16 times back-to-back, for example repeated add.

## Interface

Parameters:
- none. The datapath width is fixed at 4 bits and the repeat counter at 4 bits.

Ports (name, direction, width, meaning):
- clk, in, 1: the block's single clock; all state changes on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- cmd_valid, in, 1: a command is presented.
- cmd_ready, out, 1: the controller can accept a command.
- cmd_op, in, 3: opcode, which is the multiplexer select code.
- cmd_b, in, 4: operand B, or the load value.
- cmd_load, in, 1: 1 = load cmd_b into the accumulator; no ALU operation.
- cmd_rep, in, 4: execute the operation cmd_rep+1 times.
- s2, s1, s0, out, 1 each: select lines to the result multiplexer stage.
- alu_a, out, 4: operand A; always equals acc.
- alu_b, out, 4: latched operand B.
- alu_y, in, 4: combinational result from the multiplexer stage.
- alu_co, in, 1: adder carry/borrow out from the datapath.
- acc, out, 4: accumulator.
- flag_z, out, 1: last written result was zero.
- flag_c, out, 1: carry from the last EXEC cycle.
- done, out, 1: single-cycle pulse when a command completes.

## Operation

- States: IDLE, EXEC, DONE. Reset enters IDLE.
- Reset values:
  - acc = 0, flag_z = 0, flag_c = 0, done = 0.
  - alu_b = 0, select = 3'b000, count = 0.
  - cmd_ready = 0 while reset is high.
- IDLE:
  - cmd_ready = 1. A transfer occurs when cmd_valid && cmd_ready at a rising edge.
  - Load transfer (cmd_load = 1): acc <= cmd_b, flag_z <= (cmd_b == 0), flag_c <= 0; next state DONE.
  - Operation transfer: latch op into the selects, alu_b <= cmd_b, count <= cmd_rep; next state EXEC.
  - Selects drive 3'b000 in IDLE unless a command is latched.
- EXEC:
  - cmd_ready = 0.
  - Each cycle: acc <= alu_y, flag_c <= alu_co, flag_z <= (alu_y == 0).
  - If count == 0, go to DONE; otherwise count <= count − 1 and stay in EXEC.
  - Selects and alu_b stay stable for the whole of EXEC.
- DONE:
  - done = 1 for exactly one cycle; cmd_ready = 0; next state IDLE.
- Opcode map (package constants; the controller itself is opcode-agnostic):
  - ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, NOT = 5, SHL = 6, SHR = 7.
- Arithmetic wraps modulo 16; carry comes only from alu_co.
- cmd_valid while busy is ignored: no capture and no side effects.
- Reset during EXEC or DONE forces the reset values. No done pulse is produced, and the aborted command is dropped.

## Timing

- The accepting edge is cycle 0.
- Load: done is high in cycle 1; cmd_ready is high again in cycle 2.
- Operation with cmd_rep = r:
  - EXEC occupies cycles 1 .. r+1; acc updates at the end of each of those cycles.
  - done is high in cycle r+2; cmd_ready returns in cycle r+3.
  - Total latency is r+3 cycles from accept to next ready.
- alu_y / alu_co path: combinational from alu_a, alu_b and the selects, and sampled at the same edge. The datapath must settle within one clock.
- Minimum command spacing: 3 cycles for an operation, 2 for a load.

## Structure

- Shared package alu4_pkg holds:
  - the opcode constants (OP_ADD … OP_SHR, 3 bits);
  - the state encoding (ST_IDLE, ST_EXEC, ST_DONE, 2 bits);
  - the constant WIDTH = 4.
- Sub-module cnt4_dn: a 4-bit loadable down-counter with a zero flag, used for the repeat count.
- The multiplexer stage and the function units stay outside this block. The bench instantiates them together with alu4_ctrl.

## Test plan

1. Reset: hold reset for 2 cycles → acc = 0, flags = 0, done = 0, cmd_ready = 0. cmd_ready = 1 on the first cycle after reset falls.
2. Load 4'h5, then ADD b = 3, rep = 0 → acc = 8, flag_z = 0, flag_c = 0. done is high 2 cycles after the ADD accept.
3. Load 4'hF, then ADD b = 1 → acc = 0, flag_z = 1, flag_c = 1.
4. Load 0, then ADD b = 3, rep = 4 → acc steps 3, 6, 9, C, F. done in cycle 6. cmd_valid held high during EXEC is not accepted, and cmd_ready stays 0.
5. Load 0, then ADD b = 1, rep = 15; assert reset in the 3rd EXEC cycle → acc = 0, state IDLE, no done pulse, selects = 000.
6. cmd_valid held high with two queued commands (SUB b = 2 from acc = 7, then XOR b = F) → SUB gives acc = 5. XOR is accepted exactly in the cycle cmd_ready returns and gives acc = A.
